// File: rtl/data_encode_pipe.sv
// rtl/data_encode_pipe.sv - write-side SEC Hamming encoder stage with skid buffer and error injection
// 32-bit data in, 38-bit inverted-data Hamming codeword out; one registered stage with valid/ready on both sides.
module data_encode_pipe #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   input  logic             inj_arm,
   input  logic [1:0]       inj_mode,
   input  logic [5:0]       inj_pos,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [37:0]      out_data,
   output logic             out_inj,
   output logic [CNT_W-1:0] beat_cnt,
   output logic [CNT_W-1:0] inj_cnt
);

   // Data bits go to non-power-of-two positions inverted, so all-ones data encodes to all zeros.
   function automatic logic [37:0] encode(input logic [31:0] d);
      logic [37:0] w;
      logic [5:0]  pos;
      logic        p;
      int          j;
      w = '0;
      j = 0;
      for (int i = 0; i < 38; i++) begin
         pos = 6'(i + 1);
         if ((pos & (pos - 6'd1)) != 6'd0) begin
            w[i] = ~d[j];
            j++;
         end
      end
      for (int k = 0; k < 6; k++) begin
         p = 1'b0;
         for (int i = 0; i < 38; i++) begin
            if ((((i + 1) >> k) & 1) != 0) p = p ^ w[i];
         end
         w[(1 << k) - 1] = p;
      end
      return w;
   endfunction

   logic        ov;
   logic        sv;
   logic        inj_pend;
   logic [37:0] sk_data;
   logic        sk_inj;

   logic        fire_in;
   logic        fire_out;
   logic        inj_eff;
   logic        inj_hit;
   logic [5:0]  p2;
   logic [37:0] flip_mask;
   logic [37:0] cw_in;

   assign in_ready  = ~sv & ~rst;
   assign out_valid = ov;

   always_comb begin
      fire_in   = in_valid & in_ready;
      fire_out  = ov & out_ready;
      inj_eff   = inj_pend | inj_arm;
      p2        = (inj_pos == 6'd37) ? 6'd0 : inj_pos + 6'd1;
      flip_mask = '0;
      inj_hit   = 1'b0;
      if (inj_eff && (inj_pos <= 6'd37)) begin
         case (inj_mode)
            2'b01: begin
               flip_mask = 38'd1 << inj_pos;
               inj_hit   = 1'b1;
            end
            2'b10: begin
               flip_mask = (38'd1 << inj_pos) | (38'd1 << p2);
               inj_hit   = 1'b1;
            end
            default: begin
               flip_mask = '0;
               inj_hit   = 1'b0;
            end
         endcase
      end
      cw_in = encode(in_data) ^ flip_mask;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ov       <= 1'b0;
         sv       <= 1'b0;
         inj_pend <= 1'b0;
         out_data <= '0;
         out_inj  <= 1'b0;
         sk_data  <= '0;
         sk_inj   <= 1'b0;
         beat_cnt <= '0;
         inj_cnt  <= '0;
      end else begin
         // A pending arm is consumed by the next accepted beat even if no flip applies.
         if (fire_in)
            inj_pend <= 1'b0;
         else if (inj_arm)
            inj_pend <= 1'b1;

         if (fire_out) begin
            if (beat_cnt != '1) beat_cnt <= beat_cnt + CNT_W'(1);
            if (out_inj && (inj_cnt != '1)) inj_cnt <= inj_cnt + CNT_W'(1);
         end

         if (!ov || fire_out) begin
            ov <= sv | fire_in;
            sv <= 1'b0;
            if (sv) begin
               out_data <= sk_data;
               out_inj  <= sk_inj;
            end else if (fire_in) begin
               out_data <= cw_in;
               out_inj  <= inj_hit;
            end
         end else if (fire_in) begin
            sk_data <= cw_in;
            sk_inj  <= inj_hit;
            sv      <= 1'b1;
         end
      end
   end

endmodule
